// File: rtl/ultrasonic_range_frontend.sv
// Ultrasonic range front-end for the forward ranger.
// Fires periodic trigger pulses and times the returning echo in centimetres.
// Samples are box-car averaged into leading_distance for the car control FSM.
// A stuck or implausible echo raises a sticky sensor_fault.
module ultrasonic_range_frontend #(
   parameter int CLK_PER_CM       = 58,
   parameter int TRIG_CYCLES      = 10,
   parameter int ECHO_WAIT_CYCLES = 2000,
   parameter int PERIOD_CYCLES    = 60000,
   parameter int AVG_LOG2         = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       echo_in,
   input  logic       fault_clr,
   output logic       trig_out,
   output logic [6:0] leading_distance,
   output logic       dist_valid,
   output logic       sensor_fault
);

   localparam int DEPTH = 2 ** AVG_LOG2;
   localparam int SUMW  = 7 + AVG_LOG2;
   localparam int PCW   = $clog2(PERIOD_CYCLES + 1);
   localparam int TCW   = $clog2(TRIG_CYCLES + 1);
   localparam int WCW   = $clog2(ECHO_WAIT_CYCLES + 1);
   localparam int SCW   = $clog2(CLK_PER_CM + 1);

   localparam logic [PCW-1:0] PERIOD_LAST = PCW'(PERIOD_CYCLES - 1);
   localparam logic [TCW-1:0] TRIG_LAST   = TCW'(TRIG_CYCLES - 1);
   localparam logic [WCW-1:0] WAIT_LAST   = WCW'(ECHO_WAIT_CYCLES - 1);
   localparam logic [SCW-1:0] SUB_LAST    = SCW'(CLK_PER_CM - 1);
   localparam logic [6:0]     CM_MAX      = 7'd127;

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] TRIG      = 3'd1;
   localparam logic [2:0] WAIT_ECHO = 3'd2;
   localparam logic [2:0] MEASURE   = 3'd3;
   localparam logic [2:0] HOLDOFF   = 3'd4;

   logic           echo_meta;
   logic           echo_s;
   logic           echo_d;
   logic           rise;
   logic           fall;
   logic [2:0]     state;
   logic [PCW-1:0] period_cnt;
   logic [TCW-1:0] trig_cnt;
   logic [WCW-1:0] wait_cnt;
   logic [SCW-1:0] sub;
   logic [6:0]     cm;
   logic [6:0]     measured;
   logic [6:0]     raw;
   logic           sample_valid;
   logic           period_last;
   logic           enter_trig;
   logic           stuck;
   logic           fault_set;
   logic           prefill_req;
   logic [6:0]     avg_buf [DEPTH];
   logic [AVG_LOG2-1:0] ptr;
   logic [SUMW-1:0] sum;
   logic           empty;

   // Bring the asynchronous echo into the clock domain and keep a delayed copy for edges
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         echo_meta <= 1'b0;
         echo_s    <= 1'b0;
         echo_d    <= 1'b0;
      end else begin
         echo_meta <= echo_in;
         echo_s    <= echo_meta;
         echo_d    <= echo_s;
      end
   end

   assign rise = echo_s & ~echo_d;
   assign fall = ~echo_s & echo_d;

   assign period_last = (period_cnt == PERIOD_LAST);
   assign enter_trig  = enable && ((state == IDLE) || (state == HOLDOFF && period_last));
   assign stuck       = (state == MEASURE) && !fall && period_last;
   assign fault_set   = (enter_trig && echo_s) || stuck;
   assign prefill_req = (state == IDLE) && enable;

   // The echo that ends on a wrap cycle has completed one more full centimetre
   assign measured = (sub == SUB_LAST && cm != CM_MAX) ? cm + 7'd1 : cm;

   assign trig_out = (state == TRIG);

   // Measurement sequencer: trigger, wait for echo, time it, then hold off to period end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         period_cnt   <= '0;
         trig_cnt     <= '0;
         wait_cnt     <= '0;
         sub          <= '0;
         cm           <= '0;
         raw          <= '0;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         if (state != IDLE && !period_last)
            period_cnt <= period_cnt + 1'b1;
         case (state)
            IDLE: begin
               if (enable) begin
                  state      <= TRIG;
                  period_cnt <= '0;
                  trig_cnt   <= '0;
               end
            end
            TRIG: begin
               if (trig_cnt == TRIG_LAST) begin
                  state    <= WAIT_ECHO;
                  wait_cnt <= '0;
               end else begin
                  trig_cnt <= trig_cnt + 1'b1;
               end
            end
            WAIT_ECHO: begin
               if (rise) begin
                  state <= MEASURE;
                  cm    <= '0;
                  sub   <= '0;
               end else if (wait_cnt == WAIT_LAST) begin
                  raw          <= CM_MAX;
                  sample_valid <= 1'b1;
                  state        <= HOLDOFF;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            MEASURE: begin
               if (fall) begin
                  raw          <= measured;
                  sample_valid <= 1'b1;
                  state        <= HOLDOFF;
               end else if (period_last) begin
                  state <= HOLDOFF;
               end else if (sub == SUB_LAST) begin
                  sub <= '0;
                  if (cm != CM_MAX)
                     cm <= cm + 7'd1;
               end else begin
                  sub <= sub + 1'b1;
               end
            end
            HOLDOFF: begin
               if (period_last) begin
                  if (enable) begin
                     state      <= TRIG;
                     period_cnt <= '0;
                     trig_cnt   <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Sticky fault flag; a new fault outranks a simultaneous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sensor_fault <= 1'b0;
      else if (fault_set)
         sensor_fault <= 1'b1;
      else if (fault_clr)
         sensor_fault <= 1'b0;
   end

   // Running box-car average; the first sample of a run fills every slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            avg_buf[i] <= '0;
         sum        <= '0;
         ptr        <= '0;
         empty      <= 1'b1;
         dist_valid <= 1'b0;
      end else begin
         dist_valid <= sample_valid;
         if (sample_valid) begin
            if (empty) begin
               for (int i = 0; i < DEPTH; i++)
                  avg_buf[i] <= raw;
               sum   <= {raw, {AVG_LOG2{1'b0}}};
               ptr   <= '0;
               empty <= 1'b0;
            end else begin
               avg_buf[ptr] <= raw;
               sum          <= sum - SUMW'(avg_buf[ptr]) + SUMW'(raw);
               ptr          <= ptr + 1'b1;
            end
         end else if (prefill_req) begin
            empty <= 1'b1;
         end
      end
   end

   // A faulted sensor reads as zero distance so the car brakes
   assign leading_distance = sensor_fault ? 7'd0 : sum[SUMW-1:AVG_LOG2];

endmodule
